// File: rtl/csa_dot_seq.sv
// Multi-cycle packed-SIMD dot-product-accumulate sequencer around one 8-input carry-save tree.
// Optional feature macro: CSA_DOT_SAT_EN (clamps the final sum to 32 bits and reports rsp_sat).

module csa_tree_8 (
  input  logic [7:0][63:0] x,
  output logic [63:0]      s,
  output logic [63:0]      c
);
  logic [63:0] s1a, c1a, s1b, c1b, s2a, c2a, s2b, c2b, s3, c3;

  // Four levels of 3:2 compressors (8 -> 6 -> 4 -> 3 -> 2); carries come out pre-shifted.
  assign s1a = x[0] ^ x[1] ^ x[2];
  assign c1a = ((x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2])) << 1;
  assign s1b = x[3] ^ x[4] ^ x[5];
  assign c1b = ((x[3] & x[4]) | (x[3] & x[5]) | (x[4] & x[5])) << 1;
  assign s2a = s1a ^ c1a ^ s1b;
  assign c2a = ((s1a & c1a) | (s1a & s1b) | (c1a & s1b)) << 1;
  assign s2b = c1b ^ x[6] ^ x[7];
  assign c2b = ((c1b & x[6]) | (c1b & x[7]) | (x[6] & x[7])) << 1;
  assign s3  = s2a ^ c2a ^ s2b;
  assign c3  = ((s2a & c2a) | (s2a & s2b) | (c2a & s2b)) << 1;
  assign s   = s3 ^ c3 ^ c2b;
  assign c   = ((s3 & c3) | (s3 & c2b) | (c3 & c2b)) << 1;
endmodule

// Handshakes: a request transfers on a rising edge where req_valid && req_ready; a response
// transfers where rsp_valid && rsp_ready. rsp_data/rsp_sat hold while rsp_valid is waiting.
module csa_dot_seq #(
  parameter int LANES_PER_PASS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mode,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_acc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_sat,
  output logic        busy,
  output logic [1:0]  dbg_state
);
  typedef enum logic [1:0] {IDLE, RUN, ADD, DONE} state_t;

  state_t      state;
  logic [31:0] a_q, b_q;
  logic [1:0]  mode_q, pass_q, last_pass;
  logic        sgn_q;
  logic [63:0] s_q, c_q, tree_s, tree_c;
  logic [7:0][63:0] tree_x;
  logic [31:0] res;
  logic        sat;

  function automatic logic [63:0] lane_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] mode, input logic sgn,
                                            input logic [4:0] idx);
    logic [4:0]         w, nl;
    logic [9:0]         sh;
    logic [31:0]        ra, rb;
    logic [16:0]        ea, eb;
    logic signed [33:0] sa, sb, p;
    case (mode)
      2'd0:    begin w = 5'd16; nl = 5'd2;  end
      2'd1:    begin w = 5'd8;  nl = 5'd4;  end
      2'd2:    begin w = 5'd4;  nl = 5'd8;  end
      default: begin w = 5'd2;  nl = 5'd16; end
    endcase
    sh = 10'(idx) * 10'(w);
    ra = a >> sh;
    rb = b >> sh;
    case (mode)
      2'd0: begin
        ea = {sgn & ra[15], ra[15:0]};
        eb = {sgn & rb[15], rb[15:0]};
      end
      2'd1: begin
        ea = {{9{sgn & ra[7]}}, ra[7:0]};
        eb = {{9{sgn & rb[7]}}, rb[7:0]};
      end
      2'd2: begin
        ea = {{13{sgn & ra[3]}}, ra[3:0]};
        eb = {{13{sgn & rb[3]}}, rb[3:0]};
      end
      default: begin
        ea = {{15{sgn & ra[1]}}, ra[1:0]};
        eb = {{15{sgn & rb[1]}}, rb[1:0]};
      end
    endcase
    sa = 34'($signed(ea));
    sb = 34'($signed(eb));
    p  = sa * sb;
    if (idx >= nl) return 64'd0;
    return {{30{p[33]}}, p};
  endfunction

  always_comb begin
    tree_x = '0;
    for (int j = 0; j < LANES_PER_PASS; j++)
      tree_x[j] = lane_prod(a_q, b_q, mode_q, sgn_q, 5'(32'(pass_q) * LANES_PER_PASS + j));
    tree_x[6] = s_q;
    tree_x[7] = c_q;
  end

  csa_tree_8 u_tree (.x(tree_x), .s(tree_s), .c(tree_c));

  always_comb begin
    case (mode_q)
      2'd2:    last_pass = 2'd1;
      2'd3:    last_pass = 2'd2;
      default: last_pass = 2'd0;
    endcase
  end

`ifdef CSA_DOT_SAT_EN
  localparam logic signed [63:0] SMAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SMIN = 64'shFFFF_FFFF_8000_0000;
  logic [63:0] sum;
  always_comb begin
    sum = s_q + c_q;
    res = sum[31:0];
    sat = 1'b0;
    if (sgn_q) begin
      if ($signed(sum) > SMAX) begin
        res = 32'h7FFF_FFFF;
        sat = 1'b1;
      end else if ($signed(sum) < SMIN) begin
        res = 32'h8000_0000;
        sat = 1'b1;
      end
    end else if (sum > 64'h0000_0000_FFFF_FFFF) begin
      res = 32'hFFFF_FFFF;
      sat = 1'b1;
    end
  end
`else
  // Only the low word matters when wrapping, so the upper half of the add is never built.
  always_comb begin
    res = s_q[31:0] + c_q[31:0];
    sat = 1'b0;
  end
`endif

  assign req_ready = (state == IDLE) && !flush;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      mode_q    <= '0;
      sgn_q     <= 1'b0;
      pass_q    <= '0;
      s_q       <= '0;
      c_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_sat   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          a_q    <= req_a;
          b_q    <= req_b;
          mode_q <= req_mode;
          sgn_q  <= req_signed;
          s_q    <= req_signed ? {{32{req_acc[31]}}, req_acc} : {32'b0, req_acc};
          c_q    <= '0;
          pass_q <= '0;
          state  <= RUN;
        end
        RUN: begin
          s_q    <= tree_s;
          c_q    <= tree_c;
          pass_q <= pass_q + 2'd1;
          if (pass_q == last_pass) state <= ADD;
        end
        ADD: begin
          rsp_data  <= res;
          rsp_sat   <= sat;
          rsp_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csa_dot_seq.sv
// Directed self-checking bench for csa_dot_seq; expectations follow CSA_DOT_SAT_EN when defined.

module tb_csa_dot_seq;
  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, req_signed;
  logic [1:0]  req_mode, dbg_state;
  logic [31:0] req_a, req_b, req_acc, rsp_data;
  logic        rsp_valid, rsp_ready, rsp_sat, busy;
  int          n_checks = 0;
  int          n_fail   = 0;

  csa_dot_seq dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_signed(req_signed), .req_a(req_a), .req_b(req_b), .req_acc(req_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_sat(rsp_sat), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] mode, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                        input logic [31:0] exp_data, input logic exp_sat,
                        input int exp_lat, input int hold);
    int n;
    @(negedge clk);
    req_mode = mode; req_signed = sgn; req_a = a; req_b = b; req_acc = acc;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_sat"}, 32'(rsp_sat), 32'(exp_sat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_data"}, rsp_data, exp_data);
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_mode = '0; req_signed = 1'b0; req_a = '0; req_b = '0; req_acc = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_data", rsp_data, 32'd0);
    check("reset_rsp_sat", 32'(rsp_sat), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    run_op("int8_u_basic", 2'd1, 1'b0, 32'h04030201, 32'h01010101, 32'd10, 32'h14, 1'b0, 2, 0);
    run_op("int8_s_neg", 2'd1, 1'b1, 32'hFFFFFFFF, 32'h01010101, 32'd0, 32'hFFFFFFFC, 1'b0, 2, 0);
    run_op("int8_u_max", 2'd1, 1'b0, 32'hFFFFFFFF, 32'h01010101, 32'd0, 32'h000003FC, 1'b0, 2, 0);
    run_op("int2_s", 2'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h10, 1'b0, 4, 0);
    run_op("int2_u", 2'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'h90, 1'b0, 4, 0);
    run_op("int4_u", 2'd2, 1'b0, 32'h11111111, 32'h22222222, 32'd5, 32'h15, 1'b0, 3, 0);
    run_op("int16_u", 2'd0, 1'b0, 32'hFFFF0002, 32'h00030004, 32'd1, 32'h00030006, 1'b0, 2, 0);
`ifdef CSA_DOT_SAT_EN
    run_op("int16_s_pos_ovf", 2'd0, 1'b1, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 2, 0);
    run_op("int16_s_neg_ovf", 2'd0, 1'b1, 32'h80008000, 32'h7FFF7FFF, 32'h80000000, 32'h80000000, 1'b1, 2, 0);
    run_op("int8_u_ovf", 2'd1, 1'b0, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2, 0);
`else
    run_op("int16_s_pos_ovf", 2'd0, 1'b1, 32'h7FFF7FFF, 32'h7FFF7FFF, 32'h7FFFFFFF, 32'hFFFE0001, 1'b0, 2, 0);
    run_op("int16_s_neg_ovf", 2'd0, 1'b1, 32'h80008000, 32'h7FFF7FFF, 32'h80000000, 32'h00010000, 1'b0, 2, 0);
    run_op("int8_u_ovf", 2'd1, 1'b0, 32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 2, 0);
`endif
    run_op("backpressure", 2'd1, 1'b0, 32'h04030201, 32'h01010101, 32'd10, 32'h14, 1'b0, 2, 5);

    // Kill an INT4 op while it is in its second RUN pass.
    @(negedge clk);
    req_mode = 2'd2; req_signed = 1'b0; req_a = 32'h11111111; req_b = 32'h22222222; req_acc = 32'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("flush_in_run_state", 32'(dbg_state), 32'd1);
    @(posedge clk);
    #1 flush = 1'b1;
    check("flush_pass1_state", 32'(dbg_state), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_rsp", 32'(seen), 32'd0);

    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    #1 check("flush_idle_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1 check("flush_idle_no_accept", 32'(busy), 32'd0);
    req_valid = 1'b0; flush = 1'b0;

    run_op("after_flush", 2'd2, 1'b0, 32'h11111111, 32'h22222222, 32'd5, 32'h15, 1'b0, 3, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
